// File: rtl/writeback_multi_if.sv
// Bundle, regfile-write, counter and commit-trace signals of the writeback_multi stage.
// slave is the stage side; master is the upstream/regfile/trace-sink side.
interface writeback_multi_if #(
   parameter int unsigned NUM_LANES = 2
);

   logic                    flush_i;
   logic                    stall_i;
   logic                    stall_o;

   logic [NUM_LANES-1:0]    in_valid;
   logic [NUM_LANES-1:0]    in_we;
   logic [5*NUM_LANES-1:0]  in_rd;
   logic [32*NUM_LANES-1:0] in_data;
   logic [32*NUM_LANES-1:0] in_pc;

   logic [NUM_LANES-1:0]    reg_we;
   logic [5*NUM_LANES-1:0]  reg_idx;
   logic [32*NUM_LANES-1:0] reg_data;

   logic [63:0]             instret;
   logic [63:0]             cycle_cnt;

   logic                    trace_valid;
   logic                    trace_ready;
   logic [NUM_LANES-1:0]    trace_mask;
   logic [32*NUM_LANES-1:0] trace_pc;
   logic [NUM_LANES-1:0]    trace_we;
   logic [5*NUM_LANES-1:0]  trace_rd;
   logic [32*NUM_LANES-1:0] trace_data;

   modport slave (
      input  flush_i, stall_i, in_valid, in_we, in_rd, in_data, in_pc, trace_ready,
      output stall_o, reg_we, reg_idx, reg_data, instret, cycle_cnt,
             trace_valid, trace_mask, trace_pc, trace_we, trace_rd, trace_data
   );

   modport master (
      output flush_i, stall_i, in_valid, in_we, in_rd, in_data, in_pc, trace_ready,
      input  stall_o, reg_we, reg_idx, reg_data, instret, cycle_cnt,
             trace_valid, trace_mask, trace_pc, trace_we, trace_rd, trace_data
   );

endinterface

// File: rtl/writeback_multi.sv
// N-lane writeback stage: regfile write ports with youngest-wins WAW resolution, retire/cycle
// counters. Define COMMIT_TRACE_EN for the commit-trace FIFO and its backpressure.
module writeback_multi #(
   parameter int unsigned NUM_LANES   = 2,
   parameter int unsigned TRACE_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   writeback_multi_if.slave wb_io
);

   logic [NUM_LANES-1:0]    valid_q, valid_d;
   logic [NUM_LANES-1:0]    we_q, we_d;
   logic [5*NUM_LANES-1:0]  rd_q, rd_d;
   logic [32*NUM_LANES-1:0] data_q, data_d;
   logic [32*NUM_LANES-1:0] pc_q, pc_d;
   logic [63:0]             instret_q, instret_d;
   logic [63:0]             cycle_q, cycle_d;

   logic                    any_valid;
   logic                    blocked;
   logic                    fire;
   logic                    stall_out;
   logic [NUM_LANES-1:0]    commit_we;
   logic [2:0]              pop_cnt;

   assign any_valid = |valid_q;
   assign fire      = any_valid & ~blocked;
   assign stall_out = wb_io.stall_i | blocked;

   // A lane loses its write if any younger valid lane writes the same rd.
   always_comb begin
      commit_we = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         commit_we[i] = fire & valid_q[i] & we_q[i] & (rd_q[5*i+:5] != 5'd0);
         for (int unsigned j = i + 1; j < NUM_LANES; j++) begin
            if (valid_q[j] && we_q[j] && (rd_q[5*j+:5] == rd_q[5*i+:5])) begin
               commit_we[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      pop_cnt = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         pop_cnt = pop_cnt + {2'b00, valid_q[i]};
      end
   end

   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      rd_d    = rd_q;
      data_d  = data_q;
      pc_d    = pc_q;
      if (wb_io.flush_i) begin
         valid_d = '0;
      end else if (!stall_out) begin
         valid_d = wb_io.in_valid;
         we_d    = wb_io.in_we;
         rd_d    = wb_io.in_rd;
         data_d  = wb_io.in_data;
         pc_d    = wb_io.in_pc;
      end else if (fire && wb_io.stall_i) begin
         // Committed while held upstream: drop it so it cannot write twice.
         valid_d = '0;
      end
   end

   assign instret_d = fire ? instret_q + {61'd0, pop_cnt} : instret_q;
   assign cycle_d   = cycle_q + 64'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= '0;
         we_q      <= '0;
         rd_q      <= '0;
         data_q    <= '0;
         pc_q      <= '0;
         instret_q <= '0;
         cycle_q   <= '0;
      end else begin
         valid_q   <= valid_d;
         we_q      <= we_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
         pc_q      <= pc_d;
         instret_q <= instret_d;
         cycle_q   <= cycle_d;
      end
   end

   assign wb_io.stall_o   = stall_out;
   assign wb_io.reg_we    = commit_we;
   assign wb_io.reg_idx   = rd_q;
   assign wb_io.reg_data  = data_q;
   assign wb_io.instret   = instret_q;
   assign wb_io.cycle_cnt = cycle_q;

`ifdef COMMIT_TRACE_EN
   localparam int unsigned PtrW = $clog2(TRACE_DEPTH);
   localparam int unsigned RecW = 71 * NUM_LANES;

   logic [RecW-1:0] mem_q [TRACE_DEPTH];
   logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic [RecW-1:0] head;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign blocked    = any_valid & fifo_full;
   // Fullness comes from registered pointers, so a same-cycle pop never makes room.
   assign push       = fire & ~fifo_full;
   assign pop        = ~fifo_empty & wb_io.trace_ready;
   assign wr_ptr_d   = wr_ptr_q + {{PtrW{1'b0}}, push};
   assign rd_ptr_d   = rd_ptr_q + {{PtrW{1'b0}}, pop};

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PtrW-1:0]] <= {valid_q, pc_q, commit_we, rd_q, data_q};
      end
   end

   assign head              = mem_q[rd_ptr_q[PtrW-1:0]];
   assign wb_io.trace_valid = ~fifo_empty;
   assign {wb_io.trace_mask, wb_io.trace_pc, wb_io.trace_we, wb_io.trace_rd,
           wb_io.trace_data} = fifo_empty ? '0 : head;
`else
   logic unused_trace;

   assign blocked           = 1'b0;
   assign wb_io.trace_valid = 1'b0;
   assign wb_io.trace_mask  = '0;
   assign wb_io.trace_pc    = '0;
   assign wb_io.trace_we    = '0;
   assign wb_io.trace_rd    = '0;
   assign wb_io.trace_data  = '0;
   assign unused_trace      = ^{pc_q, wb_io.trace_ready, (TRACE_DEPTH != 0)};
`endif

endmodule

// File: doc/writeback_multi.md
Name: writeback_multi

Overview:
- Parametrised N-lane successor of the single-lane writeback stage. Sits at the end of the pipeline, after memory2.
- Registers one bundle of up to NUM_LANES instructions and drives NUM_LANES regfile write ports.
- Resolves same-bundle WAW conflicts, counts retired instructions and cycles, and can buffer commit records for a trace/difftest sink with backpressure.

Parameters:
- NUM_LANES, 2: lanes per bundle (1..4); lane index order is program order, with lane 0 the oldest.
- TRACE_DEPTH, 4: commit-trace FIFO entries (power of 2, >=2); used only with COMMIT_TRACE_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  invalidate stage register
- stall_i  in  1  downstream/hazard stall
- stall_o  out  1  stall to upstream
- in_valid  in  NUM_LANES  per-lane valid of incoming bundle
- in_we  in  NUM_LANES  per-lane regfile write request
- in_rd  in  5*NUM_LANES  per-lane destination (lane i at [5i+:5])
- in_data  in  32*NUM_LANES  per-lane write data
- in_pc  in  32*NUM_LANES  per-lane pc
- reg_we  out  NUM_LANES  regfile write enables
- reg_idx  out  5*NUM_LANES  regfile indices
- reg_data  out  32*NUM_LANES  regfile data
- instret  out  64  retired instruction count
- cycle_cnt  out  64  cycles since reset
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  sink accepts head
- trace_mask  out  NUM_LANES  head: committed-lane mask
- trace_pc  out  32*NUM_LANES  head: per-lane pc
- trace_we  out  NUM_LANES  head: per-lane effective write enable
- trace_rd  out  5*NUM_LANES  head: per-lane rd
- trace_data  out  32*NUM_LANES  head: per-lane data

Behaviour:
- Stage register holds valid, we, rd, data and pc per lane. Reset clears all valid bits, instret, cycle_cnt and FIFO pointers. All outputs are 0 after reset.
- blocked = any register valid & fifo_full. blocked is forced to 0 without COMMIT_TRACE_EN.
- stall_o = stall_i | blocked.
- fire = any register valid & ~blocked. The register contents commit in the fire cycle; regfile outputs are combinational from the register, so latency is 1 cycle from capture to write.
- reg_we[i] = fire & valid[i] & we[i] & (rd[i]!=0) & no lane j>i with valid[j] & we[j] & rd[j]==rd[i]. The youngest writer wins.
- reg_idx and reg_data pass straight through from the register.
- Register update priority: rst, then flush_i (all valid cleared), then ~stall_o (load inputs), then fire & stall_i (valid cleared so the bundle never commits twice), else hold.
- A flush in the same cycle as fire does not cancel the current commit.
- instret += popcount(valid mask) on fire, wrapping modulo 2^64.
- cycle_cnt increments every non-reset cycle, wrapping modulo 2^64.
- FIFO:
  - Push on fire, recording the valid mask, pc, effective reg_we, rd and data.
  - Pop when trace_valid & trace_ready.
  - No push while full, even if a pop occurs the same cycle; fullness is taken from registered state.
  - Push and pop in the same cycle when not full leaves the count unchanged.
  - Pointers are log2(TRACE_DEPTH) bits plus a wrap bit. Count ranges 0..TRACE_DEPTH.
  - flush_i does not affect the FIFO.

Optional Feature:
- COMMIT_TRACE_EN defined: trace FIFO present, and backpressure via blocked is active.
- Not defined: no FIFO storage; trace_* outputs are tied to 0; stall_o = stall_i; fire = any register valid.

Test Plan:
- Reset, then 2-lane bundle {lane0 rd=3 data=0x11, lane1 rd=4 data=0x22} -> next cycle reg_we=2'b11, idx 3/4, data 0x11/0x22; instret=2.
- WAW bundle, both lanes rd=5, data 0xA/0xB -> reg_we=2'b10, r5 receives 0xB; instret +2; trace_we=2'b10.
- rd=0 write with data 0xFF -> reg_we=0 for that lane; lane still counted in instret and in trace_mask.
- stall_i held 3 cycles after a valid bundle is captured -> exactly one commit (reg_we high one cycle), instret +2 once, register then invalid.
- COMMIT_TRACE_EN, TRACE_DEPTH=4, trace_ready=0, 5 bundles sent -> 4 pushed, 5th blocks (stall_o=1, reg_we=0). Raise trace_ready -> head pc of bundle 1 pops, 5th commits the cycle after.
- flush_i asserted in the cycle a bundle commits, with a new bundle on the inputs -> current bundle writes; new bundle discarded, next cycle reg_we=0.
